calc1_port_driver: RTL
======================

Name: calc1_port_driver

Overview:
Upstream request driver for one calc1 port; instantiated once per port (4 total) in the calc1 bench.
- Accepts whole transactions (cmd, op1, op2) on a ready/valid interface and buffers them in a FIFO.
- Drives the two-cycle calc1 request protocol onto req_cmd_in/req_data_in.
- Captures the single-cycle out_resp/out_data reply and presents it on a ready/valid response interface for the scoreboard.
- Allows one outstanding command per port.

Parameters:
DEPTH, 4, transaction FIFO entries (power of 2, >=2)
TIMEOUT, 100, WAIT-state cycles before reporting a timeout (>=2)

Ports:
c_clk  in  1  clock; all logic on posedge
reset  in  1  synchronous, active-high
txn_valid  in  1  transaction offered
txn_ready  out  1  FIFO not full
txn_cmd  in  [0:3]  command
txn_op1  in  [0:31]  operand 1
txn_op2  in  [0:31]  operand 2
req_cmd_out  out  [0:3]  to DUV req_cmd_in[n]
req_data_out  out  [0:31]  to DUV req_data_in[n]
out_resp_in  in  [0:1]  from DUV out_resp[n]
out_data_in  in  [0:31]  from DUV out_data[n]
rsp_valid  out  1  response held
rsp_ready  in  1  consumer accepts
rsp_cmd  out  [0:3]  command that produced the response
rsp_resp  out  [0:1]  captured response code (0 on timeout)
rsp_data  out  [0:31]  captured data (0 on timeout)
rsp_timeout  out  1  response is a timeout
busy  out  1  state != IDLE or FIFO non-empty
err_stray  out  1  sticky: non-zero out_resp_in seen outside WAIT

Behaviour:
Reset (sync, active-high):
- FIFO flushed; state IDLE.
- req_cmd_out=0, req_data_out=0.
- rsp_valid=0, rsp_* = 0, err_stray=0.
- txn_ready=1 in the cycle after reset deasserts.
- Reset mid-operation abandons the in-flight command; no response is produced for it.

FIFO:
- Push when txn_valid && txn_ready.
- txn_ready = !full, registered count; no bypass.
- Push while full is ignored, even if a pop happens in the same cycle.
- Pointers wrap modulo DEPTH.

State machine (all outputs registered):
- IDLE: if FIFO non-empty, pop.
  - cmd==0: discard, stay IDLE, no drive, no response.
  - else: latch txn, drive req_cmd_out=cmd, req_data_out=op1 -> SEND1.
- SEND1 (one cycle): drive req_cmd_out=0, req_data_out=op2 -> SEND2.
- SEND2 (one cycle): drive both to 0, clear timer -> WAIT.
- WAIT:
  - If out_resp_in!=0: capture out_resp_in/out_data_in into rsp_resp/rsp_data, rsp_cmd=latched cmd, rsp_timeout=0, rsp_valid=1 -> HOLD.
  - Else timer++. When timer reaches TIMEOUT: rsp_resp=0, rsp_data=0, rsp_timeout=1, rsp_valid=1 -> HOLD.
- HOLD: rsp_* stable while rsp_valid && !rsp_ready. On rsp_ready: rsp_valid=0 -> IDLE. No new pop in the same edge.

Latency:
- Txn pushed at edge k -> cmd/op1 visible after edge k+1, op2 after edge k+2, WAIT from edge k+3.
- Response visible one cycle after the DUV's response cycle.

Command handling:
- Invalid commands (not 1, 2, 5, 6) are still driven; the DUV's response (expected 2) is captured unchanged. The block does no arithmetic.

err_stray:
- Set when out_resp_in!=0 in IDLE, SEND1, SEND2 or HOLD, e.g. a late response after a timeout.
- Cleared only by reset; the stray value is not captured.

Decomposition:
- calc1_pkg holds:
  - CMD_NOP/ADD/SUB/LSH/RSH (0, 1, 2, 5, 6)
  - RESP_NONE/SUCC/INOF/IERR (0..3)
  - drv_state_t enum {IDLE, SEND1, SEND2, WAIT, HOLD}
  - calc1_txn_t struct {cmd, op1, op2}
- One sub-module, calc1_sync_fifo (parameter DEPTH, payload calc1_txn_t, sync reset), owns the FIFO storage and count.

Test Plan:
1. Push {1, 5, 7}; DUV model returns resp=1, data=12 three cycles after op2 -> req sequence (1,5), (0,7), (0,0); rsp_valid=1 with rsp_cmd=1, rsp_resp=1, rsp_data=12, rsp_timeout=0; held until rsp_ready.
2. rsp_ready=0, DUV replies resp=1 to the first txn; push 5 more -> 4 accepted, txn_ready=0 on the 5th. Assert rsp_ready -> next txn driven 2 edges later, txn_ready returns high.
3. TIMEOUT=8, push {2, 9, 4}, DUV silent -> rsp_valid rises exactly 8 WAIT cycles after entry, rsp_timeout=1, rsp_resp=0, rsp_data=0.
4. After test 3, DUV asserts out_resp_in=1 in IDLE -> err_stray=1 and stays high until reset; no rsp_valid.
5. In WAIT with 2 txns queued, assert reset one cycle -> next cycle req outputs 0, rsp_valid=0, busy=0, txn_ready=1; a DUV response during reset is not captured.
6. Push {0, 3, 3} then {5, 1, 4} -> NOP consumed silently; only (5,1), (0,4) driven; DUV resp=1, data=16 captured.

Source files
------------

// File: rtl/calc1_pkg.sv
// Shared types and constants for the calc1 per-port request driver.
// Covers command/response encodings, driver FSM states and the buffered transaction.
// Types only; no timing or flow control here.
package calc1_pkg;

  localparam logic [0:3] CMD_NOP = 4'd0;
  localparam logic [0:3] CMD_ADD = 4'd1;
  localparam logic [0:3] CMD_SUB = 4'd2;
  localparam logic [0:3] CMD_LSH = 4'd5;
  localparam logic [0:3] CMD_RSH = 4'd6;

  localparam logic [0:1] RESP_NONE = 2'd0;
  localparam logic [0:1] RESP_SUCC = 2'd1;
  localparam logic [0:1] RESP_INOF = 2'd2;
  localparam logic [0:1] RESP_IERR = 2'd3;

  typedef enum logic [2:0] {IDLE, SEND1, SEND2, WAIT, HOLD} drv_state_t;

  typedef struct packed {
    logic [0:3]  cmd;
    logic [0:31] op1;
    logic [0:31] op2;
  } calc1_txn_t;

endpackage

// File: rtl/calc1_sync_fifo.sv
// Synchronous transaction FIFO: push/pop + data_i/data_o, full_o/empty_o from a registered count.
// Latency: a pushed entry is visible on data_o one edge after the push.
// Backpressure: a push while full is dropped, even when a pop happens on the same edge.
module calc1_sync_fifo
  import calc1_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       push_i,
  input  calc1_txn_t data_i,
  input  logic       pop_i,
  output calc1_txn_t data_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int AW = $clog2(DEPTH);

  calc1_txn_t    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  // Storage needs no reset; pointers and count define validity.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  // DEPTH is a power of two, so pointer increments wrap naturally.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/calc1_port_driver.sv
// calc1 port driver: txn_* in (valid/ready) -> req_cmd_out/req_data_out; out_resp_in/out_data_in -> rsp_* (valid/ready).
// Latency: cmd/op1 one edge after the pop, op2 the next edge, WAIT one edge later; reply registered one cycle.
// Backpressure: txn_ready drops when the FIFO is full; a held response blocks the next pop until rsp_ready.
module calc1_port_driver
  import calc1_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 100
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic        txn_valid,
  output logic        txn_ready,
  input  logic [0:3]  txn_cmd,
  input  logic [0:31] txn_op1,
  input  logic [0:31] txn_op2,
  output logic [0:3]  req_cmd_out,
  output logic [0:31] req_data_out,
  input  logic [0:1]  out_resp_in,
  input  logic [0:31] out_data_in,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [0:3]  rsp_cmd,
  output logic [0:1]  rsp_resp,
  output logic [0:31] rsp_data,
  output logic        rsp_timeout,
  output logic        busy,
  output logic        err_stray
);

  localparam int TW = $clog2(TIMEOUT + 1);

  drv_state_t    state_q, state_d;
  logic [0:3]    cur_cmd_q, cur_cmd_d;
  logic [0:31]   cur_op2_q, cur_op2_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [0:3]    req_cmd_q, req_cmd_d;
  logic [0:31]   req_data_q, req_data_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [0:3]    rsp_cmd_q, rsp_cmd_d;
  logic [0:1]    rsp_resp_q, rsp_resp_d;
  logic [0:31]   rsp_data_q, rsp_data_d;
  logic          rsp_timeout_q, rsp_timeout_d;
  logic          err_stray_q, err_stray_d;

  calc1_txn_t fifo_in, fifo_out;
  logic       fifo_full, fifo_empty, fifo_pop;
  logic       resp_seen, timer_done;

  assign fifo_in    = '{cmd: txn_cmd, op1: txn_op1, op2: txn_op2};
  assign resp_seen  = (out_resp_in != RESP_NONE);
  assign timer_done = (timer_q == TW'(TIMEOUT - 1));

  calc1_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (c_clk),
    .reset_i (reset),
    .push_i  (txn_valid),
    .data_i  (fifo_in),
    .pop_i   (fifo_pop),
    .data_o  (fifo_out),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // State and all registered outputs.
  always_ff @(posedge c_clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cur_cmd_q     <= '0;
      cur_op2_q     <= '0;
      timer_q       <= '0;
      req_cmd_q     <= '0;
      req_data_q    <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_cmd_q     <= '0;
      rsp_resp_q    <= '0;
      rsp_data_q    <= '0;
      rsp_timeout_q <= 1'b0;
      err_stray_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_cmd_q     <= cur_cmd_d;
      cur_op2_q     <= cur_op2_d;
      timer_q       <= timer_d;
      req_cmd_q     <= req_cmd_d;
      req_data_q    <= req_data_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_cmd_q     <= rsp_cmd_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_data_q    <= rsp_data_d;
      rsp_timeout_q <= rsp_timeout_d;
      err_stray_q   <= err_stray_d;
    end
  end

  // Next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!fifo_empty && fifo_out.cmd != CMD_NOP) state_d = SEND1;
      SEND1:   state_d = SEND2;
      SEND2:   state_d = WAIT;
      WAIT:    if (resp_seen || timer_done) state_d = HOLD;
      HOLD:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs and the FIFO pop.
  always_comb begin
    fifo_pop      = 1'b0;
    cur_cmd_d     = cur_cmd_q;
    cur_op2_d     = cur_op2_q;
    timer_d       = timer_q;
    req_cmd_d     = req_cmd_q;
    req_data_d    = req_data_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_cmd_d     = rsp_cmd_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_data_d    = rsp_data_q;
    rsp_timeout_d = rsp_timeout_q;
    // Any reply outside WAIT has no owner; flag it but never capture it.
    err_stray_d   = err_stray_q | (resp_seen && state_q != WAIT);
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          // NOP entries are consumed without touching the bus.
          if (fifo_out.cmd != CMD_NOP) begin
            cur_cmd_d  = fifo_out.cmd;
            cur_op2_d  = fifo_out.op2;
            req_cmd_d  = fifo_out.cmd;
            req_data_d = fifo_out.op1;
          end
        end
      end
      SEND1: begin
        req_cmd_d  = '0;
        req_data_d = cur_op2_q;
      end
      SEND2: begin
        req_cmd_d  = '0;
        req_data_d = '0;
        timer_d    = '0;
      end
      WAIT: begin
        if (resp_seen) begin
          rsp_valid_d   = 1'b1;
          rsp_cmd_d     = cur_cmd_q;
          rsp_resp_d    = out_resp_in;
          rsp_data_d    = out_data_in;
          rsp_timeout_d = 1'b0;
        end else if (timer_done) begin
          rsp_valid_d   = 1'b1;
          rsp_cmd_d     = cur_cmd_q;
          rsp_resp_d    = RESP_NONE;
          rsp_data_d    = '0;
          rsp_timeout_d = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      HOLD: begin
        if (rsp_ready) rsp_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign txn_ready    = !fifo_full;
  assign busy         = (state_q != IDLE) || !fifo_empty;
  assign req_cmd_out  = req_cmd_q;
  assign req_data_out = req_data_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_cmd      = rsp_cmd_q;
  assign rsp_resp     = rsp_resp_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_timeout  = rsp_timeout_q;
  assign err_stray    = err_stray_q;

endmodule
